// File: rtl/debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// debounced_updown_counter
//
// General-purpose event counter for pad-driven top levels. The raw enable and
// direction pins are each synchronised and debounced before they reach the
// counter, which supports wrap, saturate, one-shot and hold behaviour plus a
// synchronous load and clear.
//
// Parameters
//   WIDTH        counter width in bits (>= 2)
//   SYNC_STAGES  flops per input synchroniser (>= 2)
//   DB_CYCLES    consecutive differing cycles before a filtered level moves
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en_in     in   raw count enable (asynchronous)
//   dir_in    in   raw direction, 1 = up (asynchronous)
//   mode      in   00 wrap, 01 saturate, 10 one-shot, 11 hold
//   clear     in   synchronous clear of count and done
//   load      in   synchronous load of load_val (wins over clear)
//   load_val  in   value loaded into the count
//   limit     in   terminal / compare value
//   count     out  registered count
//   en_db     out  debounced enable
//   dir_db    out  debounced direction
//   match     out  combinational count == limit
//   done      out  sticky one-shot terminal flag
//   wrap      out  single-cycle pulse aligned with a wrapped count
// ---------------------------------------------------------------------------

// Synchroniser plus debounce filter for one asynchronous input.
//   i_raw    raw asynchronous input
//   o_level  filtered, registered level
module dbc_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);
    localparam int              DBW     = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DBW-1:0]         r_db_cnt;
    logic [DBW-1:0]         w_db_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_level = r_level;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Count consecutive cycles where the synchronised input disagrees with
    // the filtered level; adopt the new level on the last one of the run.
    always_comb begin
        w_db_cnt_nxt = r_db_cnt;
        w_level_nxt  = r_level;
        if (w_sync != r_level) begin
            if (r_db_cnt == DB_LAST) begin
                w_level_nxt  = w_sync;
                w_db_cnt_nxt = '0;
            end else begin
                w_db_cnt_nxt = r_db_cnt + DBW'(1);
            end
        end else begin
            w_db_cnt_nxt = '0;
        end
    end

    // Filter counter and filtered level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_db_cnt <= w_db_cnt_nxt;
            r_level  <= w_level_nxt;
        end
    end
endmodule

module debounced_updown_counter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic             dir_in,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             en_db,
    output logic             dir_db,
    output logic             match,
    output logic             done,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_en_db;
    logic             w_dir_db;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_sat;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_limit;

    dbc_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_en_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (en_in),
        .o_level (w_en_db)
    );

    dbc_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_dir_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (dir_in),
        .o_level (w_dir_db)
    );

    assign w_up       = r_count + ONE_VAL;
    assign w_dn       = r_count - ONE_VAL;
    assign w_at_max   = (r_count == MAX_VAL);
    assign w_at_zero  = (r_count == {WIDTH{1'b0}});
    assign w_at_limit = (r_count == limit);
    // Saturating step: the same rule serves saturate mode and the
    // not-yet-at-limit phase of one-shot mode.
    assign w_sat = w_dir_db ? (w_at_max  ? r_count : w_up)
                            : (w_at_zero ? r_count : w_dn);

    // Next count/done/wrap: load beats clear beats a debounced step.
    always_comb begin
        w_count_nxt = r_count;
        w_done_nxt  = r_done;
        w_wrap_nxt  = 1'b0;
        if (load) begin
            w_count_nxt = load_val;
            w_done_nxt  = 1'b0;
        end else if (clear) begin
            w_count_nxt = {WIDTH{1'b0}};
            w_done_nxt  = 1'b0;
        end else if (w_en_db) begin
            case (mode)
                2'b00: begin
                    w_count_nxt = w_dir_db ? w_up : w_dn;
                    w_wrap_nxt  = w_dir_db ? w_at_max : w_at_zero;
                end
                2'b01: begin
                    w_count_nxt = w_sat;
                end
                2'b10: begin
                    // At the limit the count parks and done latches,
                    // regardless of direction.
                    if (w_at_limit) begin
                        w_count_nxt = r_count;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = w_sat;
                    end
                end
                2'b11: begin
                    w_count_nxt = r_count;
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {WIDTH{1'b0}};
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count  = r_count;
    assign en_db  = w_en_db;
    assign dir_db = w_dir_db;
    assign done   = r_done;
    assign wrap   = r_wrap;
    assign match  = (r_count == limit);
endmodule

// File: tb/tb_debounced_updown_counter.sv
module tb_debounced_updown_counter;
    localparam int W   = 16;
    localparam int S   = 2;
    localparam int DB  = 16;
    localparam int MOD = 65536;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_in;
    logic          dir_in;
    logic [1:0]    mode;
    logic          clear;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  limit;
    logic [W-1:0]  count;
    logic          en_db;
    logic          dir_db;
    logic          match;
    logic          done;
    logic          wrap;

    int n_vec = 0;
    int n_err = 0;

    debounced_updown_counter #(.WIDTH(W), .SYNC_STAGES(S), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_in    (en_in),
        .dir_in   (dir_in),
        .mode     (mode),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .count    (count),
        .en_db    (en_db),
        .dir_db   (dir_db),
        .match    (match),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Raw samples delayed by the synchroniser, and a sliding window of the
    // last DB filter inputs: a level moves only when the whole window
    // disagrees with it.
    bit en_pipe [S];
    bit dir_pipe[S];
    bit en_win  [DB];
    bit dir_win [DB];
    bit m_en, m_dir, m_done, m_wrap;
    int m_cnt;

    task automatic m_reset();
        for (int i = 0; i < S; i++) begin en_pipe[i] = 1'b0; dir_pipe[i] = 1'b0; end
        for (int i = 0; i < DB; i++) begin en_win[i] = 1'b0; dir_win[i] = 1'b0; end
        m_en = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_wrap = 1'b0; m_cnt = 0;
    endtask

    task automatic m_edge();
        int  n;
        bit  f_en, f_dir, all_en, all_dir;
        if (!rst_n) begin
            m_reset();
        end else begin
            // counter uses the filtered levels held before this edge
            m_wrap = 1'b0;
            if (load) begin
                m_cnt = int'(load_val); m_done = 1'b0;
            end else if (clear) begin
                m_cnt = 0; m_done = 1'b0;
            end else if (m_en && mode != 2'd3) begin
                n = m_cnt + (m_dir ? 1 : -1);
                if (mode == 2'd2 && m_cnt == int'(limit)) m_done = 1'b1;
                else if (mode == 2'd0) begin
                    m_wrap = (n < 0) || (n >= MOD);
                    m_cnt  = (n + MOD) % MOD;
                end else m_cnt = (n < 0) ? 0 : ((n >= MOD) ? MOD - 1 : n);
            end
            // filter inputs are the raw values from S edges ago
            f_en = en_pipe[0]; f_dir = dir_pipe[0];
            for (int i = 0; i < S - 1; i++) begin
                en_pipe[i] = en_pipe[i+1]; dir_pipe[i] = dir_pipe[i+1];
            end
            en_pipe[S-1] = en_in; dir_pipe[S-1] = dir_in;
            for (int i = 0; i < DB - 1; i++) begin
                en_win[i] = en_win[i+1]; dir_win[i] = dir_win[i+1];
            end
            en_win[DB-1] = f_en; dir_win[DB-1] = f_dir;
            all_en = 1'b1; all_dir = 1'b1;
            for (int i = 0; i < DB; i++) begin
                if (en_win[i]  == m_en)  all_en  = 1'b0;
                if (dir_win[i] == m_dir) all_dir = 1'b0;
            end
            if (all_en)  m_en  = ~m_en;
            if (all_dir) m_dir = ~m_dir;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare();
        chk("count",  32'(count),  32'(m_cnt));
        chk("en_db",  32'(en_db),  32'(m_en));
        chk("dir_db", 32'(dir_db), 32'(m_dir));
        chk("done",   32'(done),   32'(m_done));
        chk("wrap",   32'(wrap),   32'(m_wrap));
        chk("match",  32'(match),  32'(m_cnt == int'(limit)));
    endtask

    // One clock: model follows the rising edge, outputs checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        compare();
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'hFFFE;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int en_hold, dir_hold;
        rst_n = 1'b0; en_in = 1'b0; dir_in = 1'b0; mode = 2'd0;
        clear = 1'b0; load = 1'b0; load_val = 16'h0000; limit = 16'hFFFF;
        m_reset();
        tick(); tick();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dir",   32'(dir_db), 32'h0);
        rst_n = 1'b1;
        tick();

        // 15-cycle glitch must be swallowed
        en_in = 1'b1;
        repeat (15) tick();
        en_in = 1'b0;
        repeat (30) tick();
        chk("glitch_en_db", 32'(en_db), 32'h0);
        chk("glitch_count", 32'(count), 32'h0);

        // steady enable: en_db rises exactly 18 edges later
        en_in = 1'b1; dir_in = 1'b1;
        repeat (17) tick();
        chk("db_17", 32'(en_db), 32'h0);
        tick();
        chk("db_18", 32'(en_db), 32'h1);
        chk("db_18_cnt", 32'(count), 32'h0);
        tick();
        chk("db_first_step", 32'(count), 32'h1);

        // wrap up through the top
        load = 1'b1; load_val = 16'hFFFE; tick();
        chk("wrap_load", 32'(count), 32'hFFFE);
        load = 1'b0; tick();
        chk("wrap_ffff", 32'(count), 32'hFFFF);
        tick();
        chk("wrap_zero", 32'(count), 32'h0);
        chk("wrap_pulse", 32'(wrap), 32'h1);
        tick();
        chk("wrap_one", 32'(count), 32'h1);
        chk("wrap_gone", 32'(wrap), 32'h0);

        // wrap down from zero (hold count at 0 via load while dir settles)
        dir_in = 1'b0; load = 1'b1; load_val = 16'h0000;
        repeat (20) tick();
        chk("dir_down", 32'(dir_db), 32'h0);
        load = 1'b0; tick();
        chk("wrap_dn_cnt", 32'(count), 32'hFFFF);
        chk("wrap_dn_pulse", 32'(wrap), 32'h1);

        // saturate down then up
        mode = 2'd1; load = 1'b1; load_val = 16'h0001; tick();
        load = 1'b0; tick(); tick();
        chk("sat_low", 32'(count), 32'h0);
        dir_in = 1'b1; load = 1'b1; load_val = 16'hFFFE;
        repeat (20) tick();
        load = 1'b0; tick(); tick(); tick();
        chk("sat_high", 32'(count), 32'hFFFF);
        chk("sat_nowrap", 32'(wrap), 32'h0);

        // one-shot to limit 5
        mode = 2'd2; limit = 16'd5; load = 1'b1; load_val = 16'd2; tick();
        load = 1'b0; tick(); tick(); tick();
        chk("os_at5", 32'(count), 32'd5);
        chk("os_match", 32'(match), 32'h1);
        chk("os_notdone", 32'(done), 32'h0);
        tick();
        chk("os_hold", 32'(count), 32'd5);
        chk("os_done", 32'(done), 32'h1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("os_clr_cnt", 32'(count), 32'h0);
        chk("os_clr_done", 32'(done), 32'h0);

        // load beats clear
        load = 1'b1; clear = 1'b1; load_val = 16'hABCD; tick();
        load = 1'b0; clear = 1'b0;
        chk("prio", 32'(count), 32'hABCD);

        // reset mid-operation
        limit = 16'h1234; load = 1'b1; load_val = 16'h1234; tick();
        load = 1'b0; tick();
        chk("mid_done", 32'(done), 32'h1);
        mode = 2'd3; en_in = 1'b0;
        repeat (8) tick();
        chk("mid_cnt", 32'(count), 32'h1234);
        async_reset();
        chk("ar_count", 32'(count), 32'h0);
        chk("ar_en",    32'(en_db), 32'h0);
        chk("ar_dir",   32'(dir_db), 32'h0);
        chk("ar_done",  32'(done), 32'h0);
        tick();
        rst_n = 1'b1; en_in = 1'b1; dir_in = 1'b1;
        repeat (17) tick();
        chk("ar_db_17", 32'(en_db), 32'h0);
        tick();
        chk("ar_db_18", 32'(en_db), 32'h1);

        // randomized phase
        en_hold = 0; dir_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (en_hold == 0) begin en_in = 1'($urandom); en_hold = $urandom_range(1, 40); end
            else en_hold--;
            if (dir_hold == 0) begin dir_in = 1'($urandom); dir_hold = $urandom_range(1, 60); end
            else dir_hold--;
            load  = ($urandom_range(0, 49) == 0);
            clear = ($urandom_range(0, 59) == 0);
            load_val = pick_val();
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 39) == 0)
                limit = ($urandom_range(0, 1) == 0) ? pick_val() : 16'(m_cnt + int'($urandom_range(0, 6)));
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/debounced_updown_counter.md
# debounced_updown_counter

Parametrised event counter with per-input synchroniser and debounce filter, up/down direction, synchronous load/clear, and selectable wrap, saturate, one-shot or hold behaviour. It is the general counter primitive for our TinyTapeout-style top levels. It takes raw pad-level enable/direction inputs and presents a registered count plus status flags to output muxes.

## Interface
Parameters:
- WIDTH, 16, counter width in bits (≥2)
- SYNC_STAGES, 2, flip-flops in each input synchroniser (≥2)
- DB_CYCLES, 16, consecutive stable cycles required before a debounced level changes (≥1; filter counter width = clog2(DB_CYCLES+1))

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_in  in  1  raw count enable (asynchronous to clk)
- dir_in  in  1  raw direction, 1 = up, 0 = down (asynchronous to clk)
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 hold (synchronous, not filtered)
- clear  in  1  synchronous clear of count and done
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value for load
- limit  in  WIDTH  compare/terminal value
- count  out  WIDTH  registered count
- en_db  out  1  debounced enable
- dir_db  out  1  debounced direction
- match  out  1  combinational count == limit
- done  out  1  sticky one-shot terminal flag
- wrap  out  1  one-cycle pulse on wrap-around

## Operation
- Reset: synchroniser chains, filter counters, en_db, dir_db, count, done and wrap all 0. dir_db resets to 0 (down).
- Synchroniser: en_in and dir_in each pass through their own SYNC_STAGES-flop chain.
- Debounce (one independent filter per channel): when the sync output differs from the filtered level, the filter counter increments. When it equals the filtered level, the counter returns to 0. On the cycle the counter equals DB_CYCLES-1 and the levels still differ, the filtered level takes the sync value and the counter returns to 0. A glitch shorter than DB_CYCLES cycles never propagates.
- Counter priority per cycle: load > clear > count step.
  - load: count = load_val, done = 0.
  - clear: count = 0, done = 0.
  - Otherwise step only if en_db = 1 and mode ≠ 11. Direction is taken from dir_db.
- Wrap mode (00): up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1. wrap pulses 1 on that cycle.
- Saturate mode (01): up holds at 2^WIDTH-1; down holds at 0. wrap is never asserted.
- One-shot mode (10):
  - When count == limit and en_db = 1, count holds and done sets.
  - Otherwise the counter behaves as saturate.
  - done stays 1 until load or clear, even if mode or limit changes.
- Hold mode (11): count frozen. done and wrap are unaffected (wrap stays 0).
- A mode change takes effect on the next edge. The count is not modified by the change itself.
- Arithmetic is modulo 2^WIDTH, unsigned. load_val and limit are used at full WIDTH.

## Timing
- en_in/dir_in level change to sync output: SYNC_STAGES edges.
- Sync output change to en_db/dir_db change: DB_CYCLES further edges, provided the input is stable.
- Total input-to-filtered latency: SYNC_STAGES + DB_CYCLES edges. The first count step occurs one edge after en_db rises.
- load and clear take effect on the next edge (1-cycle latency), independent of en_db.
- wrap is registered: high for exactly the cycle after the wrapping edge, aligned with the new count.
- done is registered: rises with the edge where count is already at limit and a step would occur.
- match is combinational from count and limit (zero latency).
- Asynchronous reset asserted mid-operation clears all state immediately, including partially advanced filter counters. After release, filters restart from 0.

## Test plan
- Debounce: defaults; raise en_in and hold. Required: en_db rises exactly 18 edges later; count = 1 one edge after that. A 15-cycle en_in pulse must leave en_db = 0 and count = 0.
- Wrap: WIDTH = 4, mode 00, dir up, load 14, enable. Required: count sequence 14, 15, 0, 1; wrap = 1 only with count = 0. Down from 0 gives 15 with wrap = 1.
- Saturate: WIDTH = 4, mode 01, load 14, count up. Required: count 14, 15, 15, 15; wrap stays 0. Down from 1 gives 0, 0.
- One-shot: mode 10, limit 5, load 2, count up. Required: count 2, 3, 4, 5, 5; done = 1 from the first held cycle; match = 1 at 5. A clear then gives count 0 and done 0 on the next edge.
- Priority: assert load (load_val = 0xABCD) and clear together with en_db = 1. Required: count = 0xABCD.
- Reset mid-operation: assert rst_n low with count = 0x1234, done = 1 and a half-advanced filter. Required: all outputs 0 immediately. After release, en_db needs the full 18 edges again.
